// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and helpers for the dtcore32 hazard/scoreboard unit.
package hazard_scoreboard_unit_pkg;

    localparam int NO_FORWARD_SEL = 0;

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_SB,
        STALL_FULL,
        STALL_MEM
    } stall_cause_t;

    // Forward-select width: one code per producer stage plus "no forward".
    function automatic int FWD_SEL_W(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bus request handshake seen by the hazard unit (request/complete in, timeout out).
interface hazard_scoreboard_unit_if;
    logic mem_req;
    logic mem_done;
    logic mem_timeout;

    modport master (output mem_req, output mem_done, input  mem_timeout);
    modport slave  (input  mem_req, input  mem_done, output mem_timeout);
endinterface

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// Pending-write bit vector and outstanding counter for long-latency writers.
module hazard_scoreboard
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter  int REG_ADDR_W  = 5,
    parameter  int MAX_PENDING = 4,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1),
    localparam int NUM_REGS    = 2 ** REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  complete_i,
    input  logic [REG_ADDR_W-1:0] complete_rd_i,
    output logic [NUM_REGS-1:0]   sb_o,
    output logic [CNT_W-1:0]      pending_cnt_o,
    output logic                  err_o
);
    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                clear_hit;

    assign clear_hit = complete_i & sb_q[complete_rd_i];

    // Set is applied after clear so a same-register issue/complete keeps the bit.
    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        err_d = err_q | (complete_i & ~sb_q[complete_rd_i]);
        if (clear_hit) sb_d[complete_rd_i] = 1'b0;
        if (issue_i)   sb_d[issue_rd_i]    = 1'b1;
        if (issue_i && !clear_hit)      cnt_d = cnt_q + CNT_W'(1);
        else if (clear_hit && !issue_i) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign sb_o          = sb_q;
    assign pending_cnt_o = cnt_q;
    assign err_o         = err_q;
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: N-stage forwarding, long-latency scoreboard, bus timeout.
// Optional HAZARD_PERF_CNT_EN adds per-cause stall cycle counters.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter  int NUM_FWD_STAGES     = 2,
    parameter  int REG_ADDR_W         = 5,
    parameter  int MAX_PENDING        = 4,
    parameter  int MEM_TIMEOUT_CYCLES = 0,
    localparam int SEL_W              = FWD_SEL_W(NUM_FWD_STAGES),
    localparam int CNT_W              = $clog2(MAX_PENDING + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    hazard_scoreboard_unit_if.slave              bus_if,
    input  logic [REG_ADDR_W-1:0]                id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]                id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0]                ex_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]                ex_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0]                ex_rd_addr_i,
    input  logic                                 ex_valid_i,
    input  logic                                 ex_long_op_i,
    input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_rd_addr_i,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_rd_we_i,
    input  logic                                 lat_done_i,
    input  logic [REG_ADDR_W-1:0]                lat_rd_addr_i,
    input  logic                                 mem_jump_taken_i,
    input  logic                                 ex_trap_valid_i,
    input  logic                                 mem_trap_valid_i,
    input  logic                                 wb_trap_valid_i,
    output logic [SEL_W-1:0]                     ex_forward_a_sel_o,
    output logic [SEL_W-1:0]                     ex_forward_b_sel_o,
    output logic                                 id_forward_a_o,
    output logic                                 id_forward_b_o,
    output logic                                 if_id_flush_o,
    output logic                                 id_ex_flush_o,
    output logic                                 ex_mem_flush_o,
    output logic                                 mem_wb_flush_o,
    output logic                                 if_id_stall_o,
    output logic                                 id_ex_stall_o,
    output logic                                 ex_mem_stall_o,
    output logic                                 mem_wb_stall_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]                          stall_sb_cnt_o,
    output logic [31:0]                          stall_mem_cnt_o,
    output logic [31:0]                          stall_full_cnt_o,
`endif
    output logic [CNT_W-1:0]                     pending_cnt_o,
    output logic                                 sb_err_o
);
    localparam int OLDEST = NUM_FWD_STAGES - 1;

    logic [2**REG_ADDR_W-1:0] sb_vec;
    logic lat_clear, rs1_hit, rs2_hit, waw, sb_hazard, long_want;
    logic full_stall, load_use, mem_req_stall, issue;

    always_comb begin
        ex_forward_a_sel_o = SEL_W'(NO_FORWARD_SEL);
        ex_forward_b_sel_o = SEL_W'(NO_FORWARD_SEL);
        // Walk oldest to youngest so the youngest match overrides.
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_rd_we_i[k] && ex_rs1_addr_i != '0 &&
                fwd_rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == ex_rs1_addr_i)
                ex_forward_a_sel_o = SEL_W'(k + 1);
            if (fwd_rd_we_i[k] && ex_rs2_addr_i != '0 &&
                fwd_rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == ex_rs2_addr_i)
                ex_forward_b_sel_o = SEL_W'(k + 1);
        end
    end

    assign id_forward_a_o = fwd_rd_we_i[OLDEST] && id_rs1_addr_i != '0 &&
                            fwd_rd_addr_i[OLDEST*REG_ADDR_W +: REG_ADDR_W] == id_rs1_addr_i;
    assign id_forward_b_o = fwd_rd_we_i[OLDEST] && id_rs2_addr_i != '0 &&
                            fwd_rd_addr_i[OLDEST*REG_ADDR_W +: REG_ADDR_W] == id_rs2_addr_i;

    // A bit being cleared this cycle no longer blocks its readers.
    assign lat_clear = lat_done_i & sb_vec[lat_rd_addr_i];
    assign rs1_hit   = id_rs1_addr_i != '0 && sb_vec[id_rs1_addr_i] &&
                       !(lat_clear && lat_rd_addr_i == id_rs1_addr_i);
    assign rs2_hit   = id_rs2_addr_i != '0 && sb_vec[id_rs2_addr_i] &&
                       !(lat_clear && lat_rd_addr_i == id_rs2_addr_i);
    assign long_want = ex_valid_i & ex_long_op_i;
    assign waw       = long_want && ex_rd_addr_i != '0 && sb_vec[ex_rd_addr_i] &&
                       !(lat_clear && lat_rd_addr_i == ex_rd_addr_i);
    assign sb_hazard = rs1_hit | rs2_hit | waw;

    assign full_stall    = long_want && pending_cnt_o == CNT_W'(MAX_PENDING);
    assign load_use      = long_want && ex_rd_addr_i != '0 &&
                           (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
    assign mem_req_stall = bus_if.mem_req & ~bus_if.mem_done;

    assign ex_mem_stall_o = mem_req_stall;
    assign mem_wb_stall_o = mem_req_stall;
    assign id_ex_stall_o  = mem_req_stall | full_stall;
    assign if_id_stall_o  = id_ex_stall_o | load_use | sb_hazard;

    assign if_id_flush_o  = mem_jump_taken_i | ex_trap_valid_i | mem_trap_valid_i | wb_trap_valid_i;
    assign ex_mem_flush_o = mem_jump_taken_i | mem_trap_valid_i | wb_trap_valid_i;
    assign id_ex_flush_o  = ex_mem_flush_o | ((sb_hazard | load_use) & ~id_ex_stall_o);
    assign mem_wb_flush_o = wb_trap_valid_i;

    assign issue = long_want & ~id_ex_stall_o & ~ex_mem_flush_o & (ex_rd_addr_i != '0) & ~waw;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_PENDING(MAX_PENDING)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_i      (issue),
        .issue_rd_i   (ex_rd_addr_i),
        .complete_i   (lat_done_i),
        .complete_rd_i(lat_rd_addr_i),
        .sb_o         (sb_vec),
        .pending_cnt_o(pending_cnt_o),
        .err_o        (sb_err_o)
    );

    localparam int TO_W = (MEM_TIMEOUT_CYCLES > 0) ? $clog2(MEM_TIMEOUT_CYCLES + 1) : 1;
    logic mem_timeout_q;

    generate
        if (MEM_TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT_CYCLES);
            logic [TO_W-1:0] to_cnt_q, to_cnt_d;
            logic            to_pulse_d;

            always_comb begin
                to_cnt_d   = '0;
                to_pulse_d = 1'b0;
                if (mem_req_stall) begin
                    to_cnt_d = to_cnt_q;
                    if (to_cnt_q != TO_LIMIT) begin
                        to_cnt_d   = to_cnt_q + TO_W'(1);
                        to_pulse_d = (to_cnt_d == TO_LIMIT);
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    to_cnt_q      <= '0;
                    mem_timeout_q <= 1'b0;
                end else begin
                    to_cnt_q      <= to_cnt_d;
                    mem_timeout_q <= to_pulse_d;
                end
            end
        end else begin : g_no_timeout
            assign mem_timeout_q = 1'b0;
        end
    endgenerate

    assign bus_if.mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_sb_cnt_q, stall_mem_cnt_q, stall_full_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_sb_cnt_q   <= '0;
            stall_mem_cnt_q  <= '0;
            stall_full_cnt_q <= '0;
        end else begin
            if (sb_hazard)     stall_sb_cnt_q   <= stall_sb_cnt_q + 32'd1;
            if (mem_req_stall) stall_mem_cnt_q  <= stall_mem_cnt_q + 32'd1;
            if (full_stall)    stall_full_cnt_q <= stall_full_cnt_q + 32'd1;
        end
    end

    assign stall_sb_cnt_o   = stall_sb_cnt_q;
    assign stall_mem_cnt_o  = stall_mem_cnt_q;
    assign stall_full_cnt_o = stall_full_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (MAX_PENDING=4, MEM_TIMEOUT_CYCLES=8).
module tb_hazard_scoreboard_unit;
    import hazard_scoreboard_unit_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
    logic       ex_valid_i, ex_long_op_i;
    logic [9:0] fwd_rd_addr_i;
    logic [1:0] fwd_rd_we_i;
    logic       lat_done_i;
    logic [4:0] lat_rd_addr_i;
    logic       mem_jump_taken_i, ex_trap_valid_i, mem_trap_valid_i, wb_trap_valid_i;
    logic [1:0] ex_forward_a_sel_o, ex_forward_b_sel_o;
    logic       id_forward_a_o, id_forward_b_o;
    logic       if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o;
    logic       if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o;
    logic [2:0] pending_cnt_o;
    logic       sb_err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_sb_cnt_o, stall_mem_cnt_o, stall_full_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard_unit_if bus_if ();

    hazard_scoreboard_unit #(
        .NUM_FWD_STAGES(2), .REG_ADDR_W(5), .MAX_PENDING(4), .MEM_TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus_if(bus_if),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_valid_i(ex_valid_i), .ex_long_op_i(ex_long_op_i),
        .fwd_rd_addr_i(fwd_rd_addr_i), .fwd_rd_we_i(fwd_rd_we_i),
        .lat_done_i(lat_done_i), .lat_rd_addr_i(lat_rd_addr_i),
        .mem_jump_taken_i(mem_jump_taken_i), .ex_trap_valid_i(ex_trap_valid_i),
        .mem_trap_valid_i(mem_trap_valid_i), .wb_trap_valid_i(wb_trap_valid_i),
        .ex_forward_a_sel_o(ex_forward_a_sel_o), .ex_forward_b_sel_o(ex_forward_b_sel_o),
        .id_forward_a_o(id_forward_a_o), .id_forward_b_o(id_forward_b_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mem_flush_o(ex_mem_flush_o), .mem_wb_flush_o(mem_wb_flush_o),
        .if_id_stall_o(if_id_stall_o), .id_ex_stall_o(id_ex_stall_o),
        .ex_mem_stall_o(ex_mem_stall_o), .mem_wb_stall_o(mem_wb_stall_o),
`ifdef HAZARD_PERF_CNT_EN
        .stall_sb_cnt_o(stall_sb_cnt_o), .stall_mem_cnt_o(stall_mem_cnt_o),
        .stall_full_cnt_o(stall_full_cnt_o),
`endif
        .pending_cnt_o(pending_cnt_o), .sb_err_o(sb_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Stalls packed as {if_id, id_ex, ex_mem, mem_wb}; flushes likewise.
    function automatic logic [3:0] stalls();
        return {if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o};
    endfunction
    function automatic logic [3:0] flushes();
        return {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o};
    endfunction

    initial begin
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rs1_addr_i = '0; ex_rs2_addr_i = '0;
        ex_rd_addr_i = '0; ex_valid_i = 0; ex_long_op_i = 0;
        fwd_rd_addr_i = '0; fwd_rd_we_i = '0; lat_done_i = 0; lat_rd_addr_i = '0;
        mem_jump_taken_i = 0; ex_trap_valid_i = 0; mem_trap_valid_i = 0; wb_trap_valid_i = 0;
        bus_if.mem_req = 0; bus_if.mem_done = 0;

        step(); step();
        chk("rst_cnt", 32'(pending_cnt_o), 0);
        chk("rst_err", 32'(sb_err_o), 0);
        chk("rst_timeout", 32'(bus_if.mem_timeout), 0);
        rst_i = 0;
        step();
        chk("idle_stalls", 32'(stalls()), 0);
        chk("idle_flushes", 32'(flushes()), 0);
        chk("idle_sel_a", 32'(ex_forward_a_sel_o), 0);

        // Forwarding: youngest matching stage wins.
        fwd_rd_addr_i = {5'd5, 5'd5}; fwd_rd_we_i = 2'b11; ex_rs1_addr_i = 5'd5;
        #1 chk("fwd_both", 32'(ex_forward_a_sel_o), 1);
        fwd_rd_we_i = 2'b10;
        #1 chk("fwd_old_only", 32'(ex_forward_a_sel_o), 2);
        ex_rs2_addr_i = 5'd5; fwd_rd_we_i = 2'b00;
        #1 chk("fwd_b_none", 32'(ex_forward_b_sel_o), 0);
        fwd_rd_addr_i = {5'd0, 5'd0}; fwd_rd_we_i = 2'b11; ex_rs1_addr_i = 5'd0;
        #1 chk("fwd_x0", 32'(ex_forward_a_sel_o), 0);
        fwd_rd_addr_i = {5'd9, 5'd3}; fwd_rd_we_i = 2'b10; id_rs1_addr_i = 5'd9; id_rs2_addr_i = 5'd3;
        #1 chk("id_fwd_a", 32'(id_forward_a_o), 1);
        chk("id_fwd_b", 32'(id_forward_b_o), 0);
        fwd_rd_we_i = '0; fwd_rd_addr_i = '0; ex_rs1_addr_i = '0; ex_rs2_addr_i = '0;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0;

        // Long op to x7, then a reader of x7 stalls until completion.
        ex_valid_i = 1; ex_long_op_i = 1; ex_rd_addr_i = 5'd7;
        step();
        ex_valid_i = 0; ex_long_op_i = 0; ex_rd_addr_i = '0; id_rs2_addr_i = 5'd7;
        #1 chk("x7_cnt", 32'(pending_cnt_o), 1);
        chk("x7_stall", 32'(stalls()), 4'b1000);
        chk("x7_bubble", 32'(flushes()), 4'b0100);
        step();
        chk("x7_stall_hold", 32'(if_id_stall_o), 1);
        lat_done_i = 1; lat_rd_addr_i = 5'd7;
        #1 chk("x7_release", 32'(if_id_stall_o), 0);
        step();
        lat_done_i = 0; id_rs2_addr_i = '0;
        #1 chk("x7_cnt_done", 32'(pending_cnt_o), 0);

        // Fill to MAX_PENDING, then a fifth long op is held.
        ex_valid_i = 1; ex_long_op_i = 1;
        for (int r = 1; r <= 4; r++) begin
            ex_rd_addr_i = 5'(r);
            step();
        end
        ex_rd_addr_i = 5'd6;
        #1 chk("full_cnt", 32'(pending_cnt_o), 4);
        chk("full_stall", 32'(stalls()), 4'b1100);
        lat_done_i = 1; lat_rd_addr_i = 5'd2;
        #1 chk("full_same_cycle", 32'(id_ex_stall_o), 1);
        step();
        lat_done_i = 0;
        #1 chk("full_after_done_cnt", 32'(pending_cnt_o), 3);
        chk("full_released", 32'(id_ex_stall_o), 0);
        step();
        ex_valid_i = 0; ex_long_op_i = 0; ex_rd_addr_i = '0;
        #1 chk("x6_issued_cnt", 32'(pending_cnt_o), 4);
        id_rs1_addr_i = 5'd6;
        #1 chk("x6_pending", 32'(if_id_stall_o), 1);
        id_rs1_addr_i = 5'd2;
        #1 chk("x2_cleared", 32'(if_id_stall_o), 0);
        id_rs1_addr_i = '0;

        // Completion for a register that is not pending.
        lat_done_i = 1; lat_rd_addr_i = 5'd9;
        step();
        lat_done_i = 0;
        #1 chk("err_set", 32'(sb_err_o), 1);
        chk("err_cnt", 32'(pending_cnt_o), 4);
        step();
        chk("err_sticky", 32'(sb_err_o), 1);

        // Flush combinations.
        mem_jump_taken_i = 1;
        #1 chk("flush_jump", 32'(flushes()), 4'b1110);
        mem_jump_taken_i = 0; ex_trap_valid_i = 1;
        #1 chk("flush_ex_trap", 32'(flushes()), 4'b1000);
        ex_trap_valid_i = 0; wb_trap_valid_i = 1;
        #1 chk("flush_wb_trap", 32'(flushes()), 4'b1111);
        wb_trap_valid_i = 0;

        // Completing x1 leaves three pending for the reset check later.
        lat_done_i = 1; lat_rd_addr_i = 5'd1;
        step();
        lat_done_i = 0;
        #1 chk("three_pending", 32'(pending_cnt_o), 3);

        // Bus timeout pulses on the eighth stalled cycle only.
        bus_if.mem_req = 1;
        #1 chk("mem_stalls", 32'(stalls()), 4'b1111);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("timeout_c%0d", i), 32'(bus_if.mem_timeout), (i == 8) ? 1 : 0);
        end
        chk("mem_stalls_hold", 32'(stalls()), 4'b1111);
        bus_if.mem_done = 1;
        #1 chk("mem_done_stalls", 32'(stalls()), 0);
        step();
        bus_if.mem_done = 0; bus_if.mem_req = 0;
        step();
        bus_if.mem_req = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("timeout_restart_c%0d", i), 32'(bus_if.mem_timeout), (i == 8) ? 1 : 0);
        end
        bus_if.mem_req = 0;
        step();

        // Asynchronous reset between clock edges clears everything at once.
        id_rs1_addr_i = 5'd3;
        #1 chk("pre_rst_hazard", 32'(if_id_stall_o), 1);
        #1 rst_i = 1;
        #1 chk("async_rst_cnt", 32'(pending_cnt_o), 0);
        chk("async_rst_sb", 32'(if_id_stall_o), 0);
        chk("async_rst_err", 32'(sb_err_o), 0);
        step();
        rst_i = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised hazard unit for the dtcore32 pipeline. It generalises forwarding to NUM_FWD_STAGES producer stages. It adds a register scoreboard for long-latency writers (bus loads, mul/div) with an outstanding-write limit, and a bus-request timeout counter. It sits beside the pipeline registers and drives every stall, flush and forward select.

Parameters:
NUM_FWD_STAGES, 2, producer stages after EX that can forward (index 0 = youngest, i.e. MEM).
REG_ADDR_W, 5, register address width.
MAX_PENDING, 4, maximum outstanding long-latency writes (1..2**REG_ADDR_W-1).
MEM_TIMEOUT_CYCLES, 0, bus-stall cycles before timeout; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
id_rs1_addr_i  in  REG_ADDR_W  decode rs1
id_rs2_addr_i  in  REG_ADDR_W  decode rs2
ex_rs1_addr_i  in  REG_ADDR_W  execute rs1
ex_rs2_addr_i  in  REG_ADDR_W  execute rs2
ex_rd_addr_i  in  REG_ADDR_W  execute rd
ex_valid_i  in  1  EX holds a real instruction
ex_long_op_i  in  1  EX instruction is a long-latency writer
fwd_rd_addr_i  in  NUM_FWD_STAGES*REG_ADDR_W  packed rd per producer stage
fwd_rd_we_i  in  NUM_FWD_STAGES  rd-write valid per producer stage
lat_done_i  in  1  long-latency result written this cycle
lat_rd_addr_i  in  REG_ADDR_W  rd of that completion
mem_jump_taken_i  in  1  redirect resolved in MEM
ex_trap_valid_i, mem_trap_valid_i, wb_trap_valid_i  in  1 each  trap per stage
mem_req_i  in  1  bus request active
mem_done_i  in  1  bus request complete
ex_forward_a_sel_o, ex_forward_b_sel_o  out  FWD_SEL_W  0 = none, k = stage k-1
id_forward_a_o, id_forward_b_o  out  1  WB-to-ID bypass (oldest stage)
if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  flushes
if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o  out  1 each  stalls
pending_cnt_o  out  $clog2(MAX_PENDING+1)  outstanding long writes
sb_err_o  out  1  sticky: completion for a non-pending register
mem_timeout_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset: scoreboard all 0, pending_cnt_o=0, sb_err_o=0, timeout counter 0, mem_timeout_o=0. With all inputs 0, every stall and flush output is 0.
- Forwarding (combinational): the youngest stage k with fwd_rd_we_i[k], an rd match and a nonzero rs gives sel=k+1; no match gives 0. id_forward_* compares against stage NUM_FWD_STAGES-1.
- Scoreboard: sb[r] is set at the edge where ex_valid_i & ex_long_op_i & ~id_ex_stall_o & ~ex_mem_flush_o & ex_rd_addr_i!=0. A lat_done_i with sb[lat_rd_addr_i]=1 clears the bit and decrements the count.
  - lat_done_i for a clear bit: no change; sb_err_o is set until reset.
  - Same-cycle issue and completion: the count is unchanged. If both target the same register, the set wins.
  - Flushes never clear the scoreboard, because in-flight operations still complete.
- sb_hazard:
  - ID rs1/rs2 (nonzero) has its scoreboard bit set, and that bit is not being cleared this cycle.
  - Or the ID instruction is a long op whose rd is pending (WAW). For this case ex_rd_addr_i is checked at issue, and issue is blocked.
- full_stall: pending_cnt_o==MAX_PENDING and EX wants to issue a long op. This holds ID/EX and IF/ID.
- load_use: EX long op, valid, with rd matching a nonzero ID rs.
- mem_req_stall = mem_req_i & ~mem_done_i.
- Stall outputs:
  - ex_mem_stall_o = mem_wb_stall_o = mem_req_stall.
  - id_ex_stall_o = mem_req_stall | full_stall.
  - if_id_stall_o = id_ex_stall_o | load_use | sb_hazard.
- Flush outputs:
  - if_id_flush_o = jump | any trap.
  - id_ex_flush_o = jump | mem_trap | wb_trap | (sb_hazard | load_use) & ~id_ex_stall_o. The last term inserts a bubble.
  - ex_mem_flush_o = jump | mem_trap | wb_trap.
  - mem_wb_flush_o = wb_trap.
- Timeout: the counter increments while mem_req_stall and saturates at MEM_TIMEOUT_CYCLES. mem_timeout_o pulses on the cycle the count reaches the limit. The counter clears when mem_req_stall deasserts. Reset mid-request clears it.

Optional Feature:
HAZARD_PERF_CNT_EN: adds 32-bit outputs stall_sb_cnt_o, stall_mem_cnt_o and stall_full_cnt_o. Each counts cycles of its stall cause, wraps at 2**32, and resets to 0. When the macro is undefined, these ports and the logic behind them are absent.

Decomposition:
- params_pkg gains the FWD_SEL_W function, the NO_FORWARD_SEL constant and a stall_cause_t enum (NONE, SB, FULL, MEM).
- One sub-module, hazard_scoreboard: bit vector plus pending counter, with issue/complete/error ports.

Test Plan:
- Stage 0 and stage 1 both write x5; EX rs1=x5 -> ex_forward_a_sel_o=1. Stage 0 only with we=0 -> sel=2.
- Issue long op to x7, then ID rs2=x7 -> if_id_stall_o=1 with an id_ex bubble until lat_done_i with x7. The stall drops that same cycle.
- Issue long ops to x1..x4 with MAX_PENDING=4, then a long op to x6 -> pending_cnt_o=4 and id_ex_stall_o=1. After completion of x2 -> issue proceeds and the count stays 4.
- lat_done_i for x9 while it is not pending -> sb_err_o=1 and sticks; pending_cnt_o unchanged.
- MEM_TIMEOUT_CYCLES=8, mem_req_i=1, no done -> mem_timeout_o is high only in cycle 8. Stalls persist; done clears the counter.
- Assert rst_i mid-scoreboard with 3 pending -> count 0 and all bits cleared immediately, asynchronously.
